// File: rtl/wf68k30l_data_wr_seq.sv
// wf68k30l_data_wr_seq: write-side bus sequencer with dynamic bus sizing.
// Takes one operand write request and splits it into as many bus write cycles
// as the addressed port needs. WR_RDY pulses once when the whole operand is written.
// WR_BERR pulses once when the write is aborted.
// Optional feature macro: WF68K30L_WR_BERR_RETRY_EN. When it is defined, the
// first bus error of an operand re-runs the failing bus cycle once.
module wf68k30l_data_wr_seq #(
    parameter int ADR_W   = 32,
    parameter int MAX_CYC = 4
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             WR_REQ,
    input  logic [ADR_W-1:0] WR_ADR,
    input  logic [1:0]       WR_SIZE,
    input  logic [31:0]      WR_DATA,
    input  logic [2:0]       WR_FC,
    output logic             WR_RDY,
    output logic             WR_BERR,
    output logic             BUS_REQ,
    output logic [ADR_W-1:0] BUS_ADR,
    output logic [1:0]       BUS_SIZE,
    output logic [31:0]      BUS_DATA,
    output logic [2:0]       BUS_FC,
    input  logic             BUS_ACK,
    input  logic [1:0]       BUS_PORT,
    input  logic             BUS_BERR
);

    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CYCLE = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             gap_q, gap_d;        // one idle cycle between bus cycles
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [2:0]       n_q, n_d;            // bytes still to be written, 0..4
    logic [31:0]      data_q, data_d;      // remaining bytes, left-justified
    logic [2:0]       fc_q, fc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;        // bus cycles completed for this operand
`ifdef WF68K30L_WR_BERR_RETRY_EN
    logic             retry_q, retry_d;    // one retry already spent on this operand
`endif

    logic [2:0]       n_load;              // byte count of the incoming operand
    logic [2:0]       lim;                 // bytes the port can take at this address
    logic [2:0]       k;                   // bytes moved by the acknowledged cycle

    // Operand size to byte count; the reserved encoding behaves as long.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign n_load = size_to_n(WR_SIZE);

    // Bytes accepted by the responding port: limited by port width, alignment and N.
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        lim = 3'd4 - {1'b0, adr_q[1:0]};
        case (BUS_PORT)
            2'b01:   lim = 3'd1;
            2'b10:   lim = adr_q[0] ? 3'd1 : 3'd2;
            default: ;
        endcase
        k = (n_q < lim) ? n_q : lim;
    end

    // Next-state and register-update logic of the sequencer.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        adr_d   = adr_q;
        n_d     = n_q;
        data_d  = data_q;
        fc_d    = fc_q;
        cnt_d   = cnt_q;
`ifdef WF68K30L_WR_BERR_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (WR_REQ) begin
                    adr_d   = WR_ADR;
                    fc_d    = WR_FC;
                    n_d     = n_load;
                    data_d  = WR_DATA << {3'd4 - n_load, 3'b000};
                    cnt_d   = '0;
                    gap_d   = 1'b0;
                    state_d = S_CYCLE;
                end
            end
            S_CYCLE: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (BUS_BERR) begin
`ifdef WF68K30L_WR_BERR_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                    end
`else
                    state_d = S_FAULT;
`endif
                end else if (BUS_ACK) begin
                    adr_d  = adr_q + ADR_W'(k);
                    n_d    = n_q - k;
                    data_d = data_q << {k, 3'b000};
                    cnt_d  = cnt_q + 1'b1;
                    if (n_q == k) begin
                        state_d = S_DONE;
                    end else if (cnt_d == CNT_W'(MAX_CYC)) begin
                        state_d = S_FAULT;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef WF68K30L_WR_BERR_RETRY_EN
                retry_d = 1'b0;
`endif
            end
            S_FAULT: begin
                // Unwritten bytes are dropped.
                n_d     = '0;
                data_d  = '0;
                state_d = S_IDLE;
`ifdef WF68K30L_WR_BERR_RETRY_EN
                retry_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and operand registers; reset abandons any cycle in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            adr_q   <= '0;
            n_q     <= '0;
            data_q  <= '0;
            fc_q    <= '0;
            cnt_q   <= '0;
`ifdef WF68K30L_WR_BERR_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            adr_q   <= adr_d;
            n_q     <= n_d;
            data_q  <= data_d;
            fc_q    <= fc_d;
            cnt_q   <= cnt_d;
`ifdef WF68K30L_WR_BERR_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Outputs come from state and registers. Reset drops BUS_REQ without waiting for a clock edge.
    assign BUS_REQ  = (state_q == S_CYCLE) && !gap_q;
    assign WR_RDY   = (state_q == S_DONE);
    assign WR_BERR  = (state_q == S_FAULT);
    assign BUS_ADR  = adr_q;
    assign BUS_SIZE = n_q[1:0];
    assign BUS_DATA = data_q;
    assign BUS_FC   = fc_q;

endmodule

// File: tb/tb_wf68k30l_data_wr_seq.sv
// Self-checking bench for wf68k30l_data_wr_seq. It acts as requester and as bus
// slave, and compares the observed bus cycles with a byte-level reference model.
module tb_wf68k30l_data_wr_seq;

    logic        CLK;
    logic        RESET_n;
    logic        WR_REQ;
    logic [31:0] WR_ADR;
    logic [1:0]  WR_SIZE;
    logic [31:0] WR_DATA;
    logic [2:0]  WR_FC;
    logic        WR_RDY;
    logic        WR_BERR;
    logic        BUS_REQ;
    logic [31:0] BUS_ADR;
    logic [1:0]  BUS_SIZE;
    logic [31:0] BUS_DATA;
    logic [2:0]  BUS_FC;
    logic        BUS_ACK;
    logic [1:0]  BUS_PORT;
    logic        BUS_BERR;

    wf68k30l_data_wr_seq #(.ADR_W(32), .MAX_CYC(4)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .WR_REQ(WR_REQ), .WR_ADR(WR_ADR), .WR_SIZE(WR_SIZE), .WR_DATA(WR_DATA), .WR_FC(WR_FC),
        .WR_RDY(WR_RDY), .WR_BERR(WR_BERR),
        .BUS_REQ(BUS_REQ), .BUS_ADR(BUS_ADR), .BUS_SIZE(BUS_SIZE), .BUS_DATA(BUS_DATA),
        .BUS_FC(BUS_FC), .BUS_ACK(BUS_ACK), .BUS_PORT(BUS_PORT), .BUS_BERR(BUS_BERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Slave behaviour per bus attempt (retries count as attempts).
    logic [1:0] cfg_port[8];
    int         cfg_wait[8];
    bit         cfg_berr[8];

    // What the slave saw.
    logic [31:0] obs_adr[$];
    logic [1:0]  obs_size[$];
    logic [31:0] obs_data[$];
    logic [2:0]  obs_fc[$];
    int          obs_gap[$];
    int rdy_cnt, berr_cnt, stable_err, end_edge, first_req_edge, extra_req;

    // What the model predicts.
    logic [31:0] exp_adr[$];
    logic [1:0]  exp_size[$];
    logic [31:0] exp_data[$];

    task automatic cfg_clear();
        for (int i = 0; i < 8; i++) begin
            cfg_port[i] = 2'b00;
            cfg_wait[i] = 0;
            cfg_berr[i] = 1'b0;
        end
    endtask

    // Byte-level reference: walk the operand bytes and let each port take what fits.
    function automatic void model_op(input logic [31:0] adr, input logic [1:0] size,
                                     input logic [31:0] data);
        int nb;
        int pos;
        int c;
        logic [7:0] b[4];
        nb = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = data >> (8 * (nb - 1 - i));
            b[i] = (i < nb) ? t[7:0] : 8'h00;
        end
        exp_adr.delete(); exp_size.delete(); exp_data.delete();
        pos = 0;
        c = 0;
        while (pos < nb) begin
            logic [31:0] a;
            logic [31:0] d;
            int rem;
            int cap;
            int kk;
            a = adr + pos;
            rem = nb - pos;
            d = 32'h0;
            for (int j = 0; j < rem; j++) d = d | ({b[pos + j], 24'h0} >> (8 * j));
            if (cfg_port[c] == 2'b01)      cap = 1;
            else if (cfg_port[c] == 2'b10) cap = 2 - int'(a[0]);
            else                           cap = 4 - int'(a[1:0]);
            kk = (rem < cap) ? rem : cap;
            exp_adr.push_back(a);
            exp_size.push_back((rem == 4) ? 2'b00 : 2'(rem));
            exp_data.push_back(d);
            pos += kk;
            c++;
        end
    endfunction

    // Issue one operand write and serve its bus cycles; records observations only.
    task automatic run_op(input logic [31:0] adr, input logic [1:0] size,
                          input logic [31:0] data, input logic [2:0] fc);
        int attempt = 0;
        int waited = 0;
        int gap = 0;
        int edges = 0;
        bit done = 1'b0;
        logic [68:0] snap = '0;
        obs_adr.delete(); obs_size.delete(); obs_data.delete(); obs_fc.delete(); obs_gap.delete();
        rdy_cnt = 0; berr_cnt = 0; stable_err = 0; end_edge = -1; first_req_edge = -1; extra_req = 0;
        WR_ADR = adr; WR_SIZE = size; WR_DATA = data; WR_FC = fc; WR_REQ = 1'b1;
        while (!done && edges < 300) begin
            @(posedge CLK); #1;
            edges++;
            BUS_ACK = 1'b0; BUS_BERR = 1'b0; BUS_PORT = 2'b00;
            if (WR_RDY)  rdy_cnt++;
            if (WR_BERR) berr_cnt++;
            if (WR_RDY || WR_BERR) begin
                WR_REQ = 1'b0;
                end_edge = edges;
                done = 1'b1;
            end else if (BUS_REQ) begin
                if (first_req_edge < 0) first_req_edge = edges;
                if (waited == 0) begin
                    snap = {BUS_ADR, BUS_SIZE, BUS_DATA, BUS_FC};
                    if (attempt > 0) obs_gap.push_back(gap);
                end else if ({BUS_ADR, BUS_SIZE, BUS_DATA, BUS_FC} !== snap) begin
                    stable_err++;
                end
                if (waited >= cfg_wait[attempt % 8]) begin
                    obs_adr.push_back(snap[68:37]);
                    obs_size.push_back(snap[36:35]);
                    obs_data.push_back(snap[34:3]);
                    obs_fc.push_back(snap[2:0]);
                    BUS_ACK  = 1'b1;
                    BUS_BERR = cfg_berr[attempt % 8];
                    BUS_PORT = cfg_port[attempt % 8];
                    attempt++;
                    waited = 0;
                    gap = 0;
                end else begin
                    waited++;
                end
            end else if (attempt > 0) begin
                gap++;
            end
        end
        WR_REQ = 1'b0;
        @(posedge CLK); #1;
        if (WR_RDY)  rdy_cnt++;
        if (WR_BERR) berr_cnt++;
        if (BUS_REQ) extra_req++;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        WR_REQ = 1'b0; WR_ADR = '0; WR_SIZE = '0; WR_DATA = '0; WR_FC = '0;
        BUS_ACK = 1'b0; BUS_PORT = '0; BUS_BERR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if ({WR_RDY, WR_BERR, BUS_REQ} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {WR_RDY, WR_BERR, BUS_REQ}); else passed++;
        total++; if (BUS_ADR !== 32'h0) $display("FAIL reset_adr: got %h want 0", BUS_ADR); else passed++;
        total++; if ({BUS_SIZE, BUS_FC} !== 5'h0) $display("FAIL reset_size_fc: got %h want 0", {BUS_SIZE, BUS_FC}); else passed++;
        total++; if (BUS_DATA !== 32'h0) $display("FAIL reset_data: got %h want 0", BUS_DATA); else passed++;
        #3 RESET_n = 1'b1;
        @(posedge CLK); #1;
        total++; if (BUS_REQ !== 1'b0) $display("FAIL idle_req: got %b want 0", BUS_REQ); else passed++;
    endtask

    task automatic test_long_aligned();
        logic [31:0] d = $urandom;
        cfg_clear();
        run_op(32'h0000_1000, 2'b00, d, 3'd5);
        total++; if (obs_adr.size() !== 1) $display("FAIL la_cycles: got %0d want 1", obs_adr.size()); else passed++;
        if (obs_adr.size() > 0) begin
            total++;
            if ({obs_adr[0], obs_size[0], obs_data[0], obs_fc[0]} !== {32'h0000_1000, 2'b00, d, 3'd5})
                $display("FAIL la_cycle0: got %h/%b/%h/%0d want 00001000/00/%h/5", obs_adr[0], obs_size[0], obs_data[0], obs_fc[0], d);
            else passed++;
        end
        total++; if (first_req_edge !== 1) $display("FAIL la_req_latency: got %0d want 1", first_req_edge); else passed++;
        total++; if (end_edge !== 2) $display("FAIL la_rdy_latency: got %0d want 2", end_edge); else passed++;
        total++; if ({rdy_cnt, berr_cnt} !== {32'd1, 32'd0}) $display("FAIL la_pulses: rdy %0d berr %0d want 1 0", rdy_cnt, berr_cnt); else passed++;
    endtask

    task automatic test_misaligned();
        cfg_clear();
        run_op(32'h0000_1001, 2'b00, 32'h1122_3344, 3'd1);
        total++; if (obs_adr.size() !== 2) $display("FAIL mis_cycles: got %0d want 2", obs_adr.size()); else passed++;
        if (obs_adr.size() == 2) begin
            total++;
            if ({obs_adr[0], obs_size[0], obs_data[0]} !== {32'h0000_1001, 2'b00, 32'h1122_3344})
                $display("FAIL mis_cycle0: got %h/%b/%h want 00001001/00/11223344", obs_adr[0], obs_size[0], obs_data[0]);
            else passed++;
            total++;
            if ({obs_adr[1], obs_size[1], obs_data[1][31:24]} !== {32'h0000_1004, 2'b01, 8'h44})
                $display("FAIL mis_cycle1: got %h/%b/%h want 00001004/01/44", obs_adr[1], obs_size[1], obs_data[1][31:24]);
            else passed++;
        end
        total++; if (end_edge !== 4) $display("FAIL mis_latency: got %0d want 4", end_edge); else passed++;
        total++; if (rdy_cnt !== 1) $display("FAIL mis_rdy: got %0d want 1", rdy_cnt); else passed++;
    endtask

    task automatic test_byte_port();
        logic [31:0] d = {16'($urandom), 16'hABCD};
        cfg_clear();
        for (int i = 0; i < 8; i++) cfg_port[i] = 2'b01;
        run_op(32'h0000_2000, 2'b10, d, 3'd2);
        total++; if (obs_adr.size() !== 2) $display("FAIL bp_cycles: got %0d want 2", obs_adr.size()); else passed++;
        if (obs_adr.size() == 2) begin
            total++;
            if ({obs_adr[0], obs_size[0], obs_data[0]} !== {32'h0000_2000, 2'b10, 32'hABCD_0000})
                $display("FAIL bp_cycle0: got %h/%b/%h want 00002000/10/abcd0000", obs_adr[0], obs_size[0], obs_data[0]);
            else passed++;
            total++;
            if ({obs_adr[1], obs_size[1], obs_data[1]} !== {32'h0000_2001, 2'b01, 32'hCD00_0000})
                $display("FAIL bp_cycle1: got %h/%b/%h want 00002001/01/cd000000", obs_adr[1], obs_size[1], obs_data[1]);
            else passed++;
        end
        total++; if (obs_gap.size() !== 1 || obs_gap[0] !== 1) $display("FAIL bp_gap: got %0d gaps want one gap of 1", obs_gap.size()); else passed++;
        total++; if (rdy_cnt !== 1) $display("FAIL bp_rdy: got %0d want 1", rdy_cnt); else passed++;
    endtask

    task automatic test_berr();
        logic [31:0] d = $urandom;
        cfg_clear();
        cfg_wait[0] = 1;
        cfg_berr[0] = 1'b1;
        run_op(32'h0000_3000, 2'b00, d, 3'd6);
`ifdef WF68K30L_WR_BERR_RETRY_EN
        total++; if ({rdy_cnt, berr_cnt} !== {32'd1, 32'd0}) $display("FAIL retry_pulses: rdy %0d berr %0d want 1 0", rdy_cnt, berr_cnt); else passed++;
        total++; if (obs_adr.size() !== 2) $display("FAIL retry_cycles: got %0d want 2", obs_adr.size()); else passed++;
        if (obs_adr.size() == 2) begin
            total++;
            if ({obs_adr[1], obs_size[1], obs_data[1]} !== {32'h0000_3000, 2'b00, d})
                $display("FAIL retry_cycle1: got %h/%b/%h want 00003000/00/%h", obs_adr[1], obs_size[1], obs_data[1], d);
            else passed++;
            total++; if (obs_gap[0] !== 1) $display("FAIL retry_gap: got %0d want 1", obs_gap[0]); else passed++;
        end
        cfg_berr[1] = 1'b1;
        run_op(32'h0000_3000, 2'b00, d, 3'd6);
        total++; if ({rdy_cnt, berr_cnt} !== {32'd0, 32'd1}) $display("FAIL berr_twice: rdy %0d berr %0d want 0 1", rdy_cnt, berr_cnt); else passed++;
        total++; if (extra_req !== 0) $display("FAIL berr_twice_idle: got %0d want 0", extra_req); else passed++;
        cfg_berr[1] = 1'b0;
        run_op(32'h0000_3004, 2'b00, d, 3'd6);
        total++; if ({rdy_cnt, berr_cnt} !== {32'd1, 32'd0}) $display("FAIL retry_flag_clear: rdy %0d berr %0d want 1 0", rdy_cnt, berr_cnt); else passed++;
`else
        total++; if ({rdy_cnt, berr_cnt} !== {32'd0, 32'd1}) $display("FAIL berr_pulses: rdy %0d berr %0d want 0 1", rdy_cnt, berr_cnt); else passed++;
        total++; if (obs_adr.size() !== 1) $display("FAIL berr_cycles: got %0d want 1", obs_adr.size()); else passed++;
        total++; if (extra_req !== 0) $display("FAIL berr_idle: got %0d want 0", extra_req); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d = $urandom;
        int bad = 0;
        cfg_clear();
        WR_ADR = 32'h0000_4000; WR_SIZE = 2'b00; WR_DATA = d; WR_FC = 3'd3; WR_REQ = 1'b1;
        @(posedge CLK); #1;
        total++; if (BUS_REQ !== 1'b1) $display("FAIL rm_req_up: got %b want 1", BUS_REQ); else passed++;
        RESET_n = 1'b0;
        WR_REQ = 1'b0;
        #1;
        total++; if ({BUS_REQ, WR_RDY, WR_BERR} !== 3'b000) $display("FAIL rm_async: got %b want 000", {BUS_REQ, WR_RDY, WR_BERR}); else passed++;
        repeat (2) @(posedge CLK);
        #3 RESET_n = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            if (BUS_REQ || WR_RDY || WR_BERR) bad++;
        end
        total++; if (bad !== 0) $display("FAIL rm_quiet: got %0d active cycles want 0", bad); else passed++;
        run_op(32'hFFFF_FFFF, 2'b01, d, 3'd7);
        total++; if (obs_adr.size() !== 1) $display("FAIL rm_wrap_cycles: got %0d want 1", obs_adr.size()); else passed++;
        if (obs_adr.size() > 0) begin
            total++;
            if ({obs_adr[0], obs_size[0], obs_data[0], obs_fc[0]} !== {32'hFFFF_FFFF, 2'b01, d[7:0], 24'h0, 3'd7})
                $display("FAIL rm_wrap_cycle0: got %h/%b/%h/%0d want ffffffff/01/%h000000/7", obs_adr[0], obs_size[0], obs_data[0], obs_fc[0], d[7:0]);
            else passed++;
        end
        total++; if ({rdy_cnt, end_edge} !== {32'd1, 32'd2}) $display("FAIL rm_wrap_rdy: rdy %0d at %0d want 1 at 2", rdy_cnt, end_edge); else passed++;
    endtask

    task automatic test_random();
        int bad_cyc = 0;
        int bad_cnt = 0;
        int bad_lat = 0;
        int bad_misc = 0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] adr = $urandom;
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            logic [2:0]  fc = 3'($urandom_range(0, 7));
            int exp_edges;
            cfg_clear();
            for (int i = 0; i < 8; i++) begin
                cfg_port[i] = 2'($urandom_range(0, 3));
                cfg_wait[i] = $urandom_range(0, 3);
            end
            model_op(adr, size, d);
            run_op(adr, size, d, fc);
            exp_edges = 1 + (exp_adr.size() - 1);
            for (int i = 0; i < exp_adr.size(); i++) exp_edges += cfg_wait[i] + 1;
            if (obs_adr.size() != exp_adr.size()) bad_cnt++;
            for (int i = 0; i < exp_adr.size() && i < obs_adr.size(); i++)
                if ({obs_adr[i], obs_size[i], obs_data[i], obs_fc[i]} !== {exp_adr[i], exp_size[i], exp_data[i], fc}) begin
                    bad_cyc++;
                    if (bad_cyc <= 3)
                        $display("FAIL rnd_cycle: op %0d cyc %0d got %h/%b/%h/%0d want %h/%b/%h/%0d", n, i,
                                 obs_adr[i], obs_size[i], obs_data[i], obs_fc[i], exp_adr[i], exp_size[i], exp_data[i], fc);
                end
            if (end_edge != exp_edges || first_req_edge != 1) bad_lat++;
            foreach (obs_gap[i]) if (obs_gap[i] != 1) bad_misc++;
            if (rdy_cnt != 1 || berr_cnt != 0 || stable_err != 0 || extra_req != 0) bad_misc++;
        end
        total++; if (bad_cnt !== 0) $display("FAIL rnd_count: got %0d ops with wrong cycle count want 0", bad_cnt); else passed++;
        total++; if (bad_cyc !== 0) $display("FAIL rnd_cycles: got %0d wrong cycles want 0", bad_cyc); else passed++;
        total++; if (bad_lat !== 0) $display("FAIL rnd_latency: got %0d ops with wrong latency want 0", bad_lat); else passed++;
        total++; if (bad_misc !== 0) $display("FAIL rnd_handshake: got %0d handshake errors want 0", bad_misc); else passed++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        cfg_clear();
        for (int n = 0; n < 8; n++) begin
            logic [31:0] adr = $urandom;
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            model_op(adr, size, d);
            run_op(adr, size, d, 3'(n));
            if (first_req_edge != 1 || rdy_cnt != 1 || obs_adr.size() != exp_adr.size()) bad++;
            else if (obs_adr[exp_adr.size() - 1] !== exp_adr[exp_adr.size() - 1] ||
                     obs_data[0] !== exp_data[0]) bad++;
        end
        total++; if (bad !== 0) $display("FAIL b2b: got %0d bad ops want 0", bad); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_long_aligned();
        test_misaligned();
        test_byte_port();
        test_berr();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
